// File: rtl/ghostbus_host.sv
// Ghostbus host: turns a valid/ready request stream into responder bus cycles and returns read data.
// Define GHOSTBUS_HOST_BURST_EN to add req_len and incrementing multi-beat reads.
module ghostbus_host #(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
`ifdef GHOSTBUS_HOST_BURST_EN
  input  logic [LEN_W-1:0] req_len,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_last,
  output logic [AW-1:0]    gb_addr,
  output logic [DW-1:0]    gb_dout,
  output logic             gb_we,
  input  logic [DW-1:0]    gb_din,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, WRITE, RADDR, RWAIT, RRESP} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    gb_addr_q, gb_addr_d;
  logic [DW-1:0]    gb_dout_q, gb_dout_d;
  logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic             rsp_last_q, rsp_last_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [LEN_W-1:0] len_in;
  logic             accept;

`ifdef GHOSTBUS_HOST_BURST_EN
  assign len_in = req_len;
`else
  assign len_in = '0;
`endif

  assign req_ready = !rst && (state_q == IDLE || state_q == WRITE);
  assign accept    = req_valid && req_ready;
  assign gb_we     = (state_q == WRITE);
  assign rsp_valid = (state_q == RRESP);
  assign busy      = (state_q != IDLE);
  assign gb_addr   = gb_addr_q;
  assign gb_dout   = gb_dout_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;

  always_comb begin
    state_d     = state_q;
    gb_addr_d   = gb_addr_q;
    gb_dout_d   = gb_dout_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_last_d  = rsp_last_q;
    cnt_d       = cnt_q;
    beats_d     = beats_q;
    unique case (state_q)
      IDLE, WRITE: begin
        state_d = IDLE;
        if (accept) begin
          gb_addr_d = req_addr;
          if (req_we) begin
            gb_dout_d = req_wdata;
            state_d   = WRITE;
          end else begin
            beats_d = len_in;
            state_d = RADDR;
          end
        end
      end
      RADDR: begin
        cnt_d   = 4'(RD_LAT - 1);
        state_d = RWAIT;
      end
      RWAIT: begin
        // cnt_q reaches zero in the last of RD_LAT wait cycles; data is valid at that edge
        if (cnt_q == 4'd0) begin
          rsp_rdata_d = gb_din;
          rsp_last_d  = (beats_q == '0);
          state_d     = RRESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RRESP: begin
        if (rsp_ready) begin
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            gb_addr_d = gb_addr_q + AW'(1);
            beats_d   = beats_q - LEN_W'(1);
            state_d   = RADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gb_addr_q   <= '0;
      gb_dout_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_last_q  <= 1'b0;
      cnt_q       <= '0;
      beats_q     <= '0;
    end else begin
      state_q     <= state_d;
      gb_addr_q   <= gb_addr_d;
      gb_dout_q   <= gb_dout_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_last_q  <= rsp_last_d;
      cnt_q       <= cnt_d;
      beats_q     <= beats_d;
    end
  end

endmodule
